arp_wavetable_seq: RTL

Parametrised arpeggiator sequencer for the Nexys A7 audio path. It sits between the debounced arpeggiator control and switches on one side and the wavetable block RAM and PWM stage on the other. It derives a base pitch from `base_sel`, steps through a configurable chord pattern, and generates wavetable read addresses at the current note's rate. The returned sample is registered for the PWM modulator.

---
 rtl/arp_pkg.sv | 66 ++++++
 rtl/arp_wavetable_seq_note_fsm.sv | 97 +++++++++
 rtl/arp_wavetable_seq.sv | 80 ++++++++
 3 files changed

// File: rtl/arp_pkg.sv
// Shared constants for the arpeggiator sequencer: note ratios, mode encodings,
// note FSM state encodings and the pattern-step helper.
package arp_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'd0;
    localparam logic [1:0] MODE_UP     = 2'd1;
    localparam logic [1:0] MODE_DOWN   = 2'd2;
    localparam logic [1:0] MODE_UPDOWN = 2'd3;

    localparam logic [1:0] ST_HOLD   = 2'd0;
    localparam logic [1:0] ST_UP     = 2'd1;
    localparam logic [1:0] ST_DOWN   = 2'd2;
    localparam logic [1:0] ST_UPDOWN = 2'd3;

    typedef enum logic [1:0] {
        S_HOLD   = ST_HOLD,
        S_UP     = ST_UP,
        S_DOWN   = ST_DOWN,
        S_UPDOWN = ST_UPDOWN
    } note_state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Entries are 9 bits wide so that the unity ratio (256) is representable.
    localparam logic [8:0] NOTE_RATIO [8] = '{9'd256, 9'd203, 9'd171, 9'd128,
                                              9'd102, 9'd85,  9'd64,  9'd51};

    // Returns {dir, note} after one pattern step in state st.
    function automatic logic [3:0] next_note(input note_state_e st,
                                             input logic [2:0] n,
                                             input logic d,
                                             input logic [2:0] last);
        logic [2:0] nn;
        logic       nd;
        nn = n;
        nd = d;
        case (st)
            S_UP:     nn = (n >= last) ? 3'd0 : n + 3'd1;
            S_DOWN:   nn = (n == 3'd0 || n > last) ? last : n - 3'd1;
            S_UPDOWN: begin
                if (d == DIR_UP) begin
                    if (n >= last) begin
                        nn = last - 3'd1;
                        nd = DIR_DOWN;
                    end else begin
                        nn = n + 3'd1;
                    end
                end else begin
                    if (n == 3'd0) begin
                        nn = 3'd1;
                        nd = DIR_UP;
                    end else begin
                        nn = n - 3'd1;
                    end
                end
            end
            default: begin
                nn = 3'd0;
                nd = DIR_UP;
            end
        endcase
        return {nd, nn};
    endfunction

endpackage

// File: rtl/arp_wavetable_seq_note_fsm.sv
// Note sequencer: dwell timer, up/down direction and the current pattern index.
// With ARP_SYNC_NOTE_EN defined, note changes are deferred to the address wrap.
module arp_note_fsm
    import arp_pkg::*;
#(
    parameter int NUM_NOTES  = 4,
    parameter int NOTE_DWELL = 25_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       rst_n,
    input  logic       arp_en,
    input  logic [1:0] mode,
    input  logic       addr_wrap,
    output logic [2:0] note
);
    // state  | meaning
    // HOLD   | arpeggio off, note parked at root, dwell cleared
    // UP     | 0 .. N-1, wrap to 0
    // DOWN   | N-1 .. 0, wrap to N-1
    // UPDOWN | bounce between ends without repeating them

    localparam int              DWELL_W    = (NOTE_DWELL > 1) ? $clog2(NOTE_DWELL) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(NOTE_DWELL - 1);
    localparam logic [2:0]      LAST       = 3'(NUM_NOTES - 1);

    note_state_e        state;
    note_state_e        target;
    logic [DWELL_W-1:0] dwell;
    logic               dir;
    logic               dwell_exp;
    logic               eff_dir;
    logic [3:0]         stepped;
`ifdef ARP_SYNC_NOTE_EN
    logic               pend_step;
`endif

    always_comb begin
        target = S_HOLD;
        if (arp_en) begin
            case (mode)
                MODE_UP:     target = S_UP;
                MODE_DOWN:   target = S_DOWN;
                MODE_UPDOWN: target = S_UPDOWN;
                default:     target = S_HOLD;
            endcase
        end
        dwell_exp = (dwell == DWELL_LAST);
        eff_dir   = (target != state) ? DIR_UP : dir;
        stepped   = next_note(target, note, eff_dir, LAST);
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HOLD;
            note  <= 3'd0;
            dwell <= '0;
            dir   <= DIR_UP;
`ifdef ARP_SYNC_NOTE_EN
            pend_step <= 1'b0;
`endif
        end else begin
            state <= target;
            if (target == S_HOLD) begin
                dwell <= '0;
                dir   <= DIR_UP;
`ifdef ARP_SYNC_NOTE_EN
                pend_step <= 1'b0;
                if (addr_wrap) note <= 3'd0;
`else
                note <= 3'd0;
`endif
            end else if (state == S_HOLD) begin
                dwell <= '0;
                dir   <= DIR_UP;
                note  <= (target == S_DOWN) ? LAST : 3'd0;
`ifdef ARP_SYNC_NOTE_EN
                pend_step <= 1'b0;
`endif
            end else begin
                dwell <= dwell_exp ? '0 : dwell + DWELL_W'(1);
`ifdef ARP_SYNC_NOTE_EN
                // Any number of expiries between wraps collapses into one step.
                pend_step <= (pend_step | dwell_exp) & ~addr_wrap;
                if (addr_wrap && (pend_step || dwell_exp)) begin
`else
                if (dwell_exp) begin
`endif
                    note <= stepped[2:0];
                    dir  <= stepped[3];
                end else begin
                    dir <= eff_dir;
                end
            end
        end
    end

endmodule

// File: rtl/arp_wavetable_seq.sv
// Arpeggiator wavetable sequencer: note-rate divider, table addressing and
// registered sample output. Optional macro: ARP_SYNC_NOTE_EN (click-free note changes).
module arp_wavetable_seq
    import arp_pkg::*;
#(
    parameter int NUM_NOTES   = 4,
    parameter int ADDR_W      = 8,
    parameter int SAMPLE_W    = 11,
    parameter int DIV_W       = 13,
    parameter int BASE_OFFSET = 746,
    parameter int NOTE_DWELL  = 25_000_000,
    parameter int RD_LAT      = 1
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    input  logic                arp_en,
    input  logic [1:0]          mode,
    input  logic [7:0]          base_sel,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [SAMPLE_W-1:0] mem_data,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic [2:0]          note
);
    localparam int PER_W = DIV_W + 1;

    logic [DIV_W-1:0]  f_base;
    logic [DIV_W+8:0]  product;
    logic [PER_W-1:0]  period_raw;
    logic [PER_W-1:0]  period;
    logic [PER_W-1:0]  div_cnt;
    logic              addr_step;
    logic              addr_wrap;
    logic [RD_LAT-1:0] rd_pipe;

    assign f_base     = DIV_W'(BASE_OFFSET) + DIV_W'(base_sel);
    assign product    = (DIV_W+9)'(f_base) * (DIV_W+9)'(NOTE_RATIO[note]);
    assign period_raw = PER_W'(product >> 8);
    assign period     = (period_raw == '0) ? PER_W'(1) : period_raw;
    // >= rather than == so a shortened period never strands the counter past it.
    assign addr_step  = (div_cnt >= period - PER_W'(1));
    assign addr_wrap  = addr_step && (mem_addr == '1);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_cnt  <= '0;
            mem_addr <= '0;
        end else if (addr_step) begin
            div_cnt  <= '0;
            mem_addr <= mem_addr + ADDR_W'(1);
        end else begin
            div_cnt <= div_cnt + PER_W'(1);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            rd_pipe      <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            rd_pipe      <= (rd_pipe << 1) | RD_LAT'(addr_step);
            sample_valid <= rd_pipe[RD_LAT-1];
            if (rd_pipe[RD_LAT-1]) sample_out <= mem_data;
        end
    end

    arp_note_fsm #(
        .NUM_NOTES  (NUM_NOTES),
        .NOTE_DWELL (NOTE_DWELL)
    ) u_note_fsm (
        .CLK100MHZ (CLK100MHZ),
        .rst_n     (CPU_RESETN),
        .arp_en    (arp_en),
        .mode      (mode),
        .addr_wrap (addr_wrap),
        .note      (note)
    );

endmodule
